// File: rtl/pc_fetch_ctrl_if.sv
// Control-unit side bus of the fetch/sequencing stage.
// master drives the decoded control signals; slave is the fetch controller.
interface pc_fetch_ctrl_if #(
  parameter int unsigned AW = 10,
  parameter int unsigned CW = 16
);
  logic          start;
  logic          s_inc;
  logic          fin;
  logic          we3;
  logic [AW-1:0] jump_addr;
  logic          alu_zero;
  logic [AW-1:0] pc;
  logic          z;
  logic          rf_we;
  logic          running;
  logic          halted;
  logic [CW-1:0] instr_count;

  modport master (
    output start, s_inc, fin, we3, jump_addr, alu_zero,
    input  pc, z, rf_we, running, halted, instr_count
  );

  modport slave (
    input  start, s_inc, fin, we3, jump_addr, alu_zero,
    output pc, z, rf_we, running, halted, instr_count
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Program-counter sequencer: IDLE/RUN/HALT control, next-PC select, zero-flag latch,
// register-file write gating and retired-instruction counting.
module pc_fetch_ctrl #(
  parameter int unsigned AW = 10,
  parameter int unsigned CW = 16
) (
  input  logic           clk,
  input  logic           reset,
  pc_fetch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          z_q, z_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      z_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    z_d     = z_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        pc_d = '0;
        if (bus.start) state_d = StRun;
      end
      StRun: begin
        // The fin instruction still retires, so it is counted.
        if (cnt_q != '1) cnt_d = cnt_q + CW'(1);
        if (bus.fin) begin
          state_d = StHalt;
        end else begin
          pc_d = bus.s_inc ? pc_q + AW'(1) : bus.jump_addr;
          if (bus.we3) z_d = bus.alu_zero;
        end
      end
      StHalt: begin
        if (bus.start) begin
          state_d = StRun;
          pc_d    = '0;
          z_d     = 1'b0;
          cnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.pc          = pc_q;
    bus.z           = z_q;
    bus.instr_count = cnt_q;
    bus.running     = (state_q == StRun);
    bus.halted      = (state_q == StHalt);
    // Stale decodes outside RUN must never write the register file.
    bus.rf_we       = bus.we3 && (state_q == StRun) && !bus.fin;
  end

endmodule
